// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the control sequencer: FSM states, control-word mux selects
// and the fixed control words driven outside EXECUTE/MEM_WAIT.
package control_sequencer_pkg;

    localparam int CW_W       = 47;
    localparam int CW_MEM_BIT = 10;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXECUTE  = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_HALTED   = 3'd4,
        ST_FAULT    = 3'd5
    } seqState_t;

    typedef enum logic [1:0] {
        SEL_IF   = 2'd0,
        SEL_EXEC = 2'd1,
        SEL_NOP  = 2'd2,
        SEL_HALT = 2'd3
    } cwSel_t;

    // Field layout: [1:0] PC select, [2] PC load, [3] instruction load, [10] memory access, [46] halt.
    localparam logic [CW_W-1:0] CW_FETCH = 47'h0000_0000_000D;
    localparam logic [CW_W-1:0] CW_NOP   = '0;
    localparam logic [CW_W-1:0] CW_HALT  = 47'h4000_0000_0000;

    function automatic cwSel_t selForState(input seqState_t s);
        case (s)
            ST_FETCH:                return SEL_IF;
            ST_EXECUTE, ST_MEM_WAIT: return SEL_EXEC;
            ST_HALTED, ST_FAULT:     return SEL_HALT;
            default:                 return SEL_NOP;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_cw_mux.sv
// 4:1 control-word mux selecting the word presented to the datapath.
module control_sequencer_cw_mux
    import control_sequencer_pkg::*;
#(
    parameter int W = 47
) (
    input  cwSel_t         sel,
    input  logic [W-1:0]   cwIf,
    input  logic [W-1:0]   cwExec,
    input  logic [W-1:0]   cwNop,
    input  logic [W-1:0]   cwHalt,
    output logic [W-1:0]   cwOut
);

    always_comb begin
        cwOut = cwNop;
        case (sel)
            SEL_IF:   cwOut = cwIf;
            SEL_EXEC: cwOut = cwExec;
            SEL_NOP:  cwOut = cwNop;
            SEL_HALT: cwOut = cwHalt;
            default:  cwOut = cwNop;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control sequencer with retired-instruction counter.
// Define MEM_TIMEOUT_EN to enable the MEM_WAIT timeout that enters FAULT.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int CW_W        = control_sequencer_pkg::CW_W,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [CW_W-1:0] decoded_cw,
    input  logic            is_halt,
    input  logic            mem_ready,
    input  logic            run,
    output logic [CW_W-1:0] control_word,
    output logic [1:0]      cw_sel,
    output logic [2:0]      state,
    output logic [15:0]     retired,
    output logic            fault
);

`ifdef MEM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [3:0] WAIT_LIMIT = 4'(MEM_TIMEOUT - 1);

    seqState_t        stateQ, stateD;
    cwSel_t           cwSelQ;
    logic [CW_W-1:0]  cwHoldQ, cwHoldD;
    logic [15:0]      retiredQ;
    logic [3:0]       waitCntQ, waitCntD;
    logic             retireInc;

    always_comb begin
        stateD    = stateQ;
        cwHoldD   = cwHoldQ;
        waitCntD  = '0;
        retireInc = 1'b0;
        case (stateQ)
            ST_FETCH: begin
                if (instr_valid) stateD = ST_DECODE;
            end
            ST_DECODE: begin
                cwHoldD = decoded_cw;
                if (is_halt) begin
                    stateD    = ST_HALTED;
                    retireInc = 1'b1;
                end else begin
                    stateD = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (cwHoldQ[CW_MEM_BIT]) begin
                    stateD = ST_MEM_WAIT;
                end else begin
                    stateD    = ST_FETCH;
                    retireInc = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // mem_ready outranks the timeout on the cycle the limit is reached
                if (mem_ready) begin
                    stateD    = ST_FETCH;
                    retireInc = 1'b1;
                end else if (TIMEOUT_EN && (waitCntQ == WAIT_LIMIT)) begin
                    stateD = ST_FAULT;
                end else begin
                    waitCntD = (waitCntQ == WAIT_LIMIT) ? waitCntQ : waitCntQ + 4'd1;
                end
            end
            ST_HALTED, ST_FAULT: begin
                if (run) stateD = ST_FETCH;
            end
            default: stateD = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stateQ   <= ST_FETCH;
            cwSelQ   <= SEL_IF;
            cwHoldQ  <= CW_W'(CW_NOP);
            retiredQ <= '0;
            waitCntQ <= '0;
        end else begin
            stateQ   <= stateD;
            cwSelQ   <= selForState(stateD);
            cwHoldQ  <= cwHoldD;
            retiredQ <= retiredQ + 16'(retireInc);
            waitCntQ <= waitCntD;
        end
    end

    control_sequencer_cw_mux #(.W(CW_W)) cwMux (
        .sel    (cwSelQ),
        .cwIf   (CW_W'(CW_FETCH)),
        .cwExec (cwHoldQ),
        .cwNop  (CW_W'(CW_NOP)),
        .cwHalt (CW_W'(CW_HALT)),
        .cwOut  (control_word)
    );

    assign cw_sel  = cwSelQ;
    assign state   = stateQ;
    assign retired = retiredQ;

`ifdef MEM_TIMEOUT_EN
    assign fault = (stateQ == ST_FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues per-cycle expectations,
// a monitor pops and compares them just after each rising edge.
module tb_control_sequencer;

    localparam logic [2:0] S_FET = 3'd0, S_DEC = 3'd1, S_EXE = 3'd2,
                           S_MEM = 3'd3, S_HLT = 3'd4, S_FLT = 3'd5;
    localparam logic [46:0] W_FETCH = 47'h0000_0000_000D;
    localparam logic [46:0] W_NOP   = 47'h0;
    localparam logic [46:0] W_HALT  = 47'h4000_0000_0000;
    localparam logic [46:0] W_ALU   = 47'h0000_1234_5000;  // bit 10 clear
    localparam logic [46:0] W_LD    = 47'h0000_ABCD_0400;  // bit 10 set

    typedef struct {
        logic [2:0]  st;
        logic [1:0]  sel;
        logic [46:0] cw;
        logic [15:0] ret;
        logic        flt;
        int          tag;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [46:0] decoded_cw = '0;
    logic        is_halt = 1'b0;
    logic        mem_ready = 1'b0;
    logic        run = 1'b0;
    logic [46:0] control_word;
    logic [1:0]  cw_sel;
    logic [2:0]  state;
    logic [15:0] retired;
    logic        fault;

    exp_t        expQ[$];
    exp_t        monE;
    logic [15:0] expRet = '0;
    int          tagN = 0;
    int          assertions = 0;
    int          failures = 0;

    control_sequencer #(.CW_W(47), .MEM_TIMEOUT(15)) dut (
        .clock        (clock),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .decoded_cw   (decoded_cw),
        .is_halt      (is_halt),
        .mem_ready    (mem_ready),
        .run          (run),
        .control_word (control_word),
        .cw_sel       (cw_sel),
        .state        (state),
        .retired      (retired),
        .fault        (fault)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int tag, input logic [63:0] act, input logic [63:0] req);
        assertions++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step %0d: got %h, want %h", name, tag, act, req);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            chk("state",        monE.tag, 64'(state),        64'(monE.st));
            chk("cw_sel",       monE.tag, 64'(cw_sel),       64'(monE.sel));
            chk("control_word", monE.tag, 64'(control_word), 64'(monE.cw));
            chk("retired",      monE.tag, 64'(retired),      64'(monE.ret));
            chk("fault",        monE.tag, 64'(fault),        64'(monE.flt));
        end
    end

    task automatic cyc(input logic rst, input logic iv, input logic hlt, input logic mr,
                       input logic rn, input logic [46:0] dcw, input logic [2:0] st,
                       input logic [1:0] sel, input logic [46:0] cw, input logic flt);
        exp_t e;
        @(negedge clock);
        reset       = rst;
        instr_valid = iv;
        is_halt     = hlt;
        mem_ready   = mr;
        run         = rn;
        decoded_cw  = dcw;
        tagN++;
        e = '{st, sel, cw, expRet, flt, tagN};
        expQ.push_back(e);
    endtask

    task automatic aluInstr(input logic [46:0] w);
        cyc(1, 1, 0, 0, 0, w, S_DEC, 2'd2, W_NOP, 0);
        cyc(1, 0, 0, 0, 0, w, S_EXE, 2'd1, w, 0);
        expRet = expRet + 16'd1;
        cyc(1, 0, 0, 0, 0, w, S_FET, 2'd0, W_FETCH, 0);
    endtask

    task automatic loadStart(input logic [46:0] w);
        cyc(1, 1, 0, 0, 0, w, S_DEC, 2'd2, W_NOP, 0);
        cyc(1, 0, 0, 0, 0, w, S_EXE, 2'd1, w, 0);
        cyc(1, 0, 0, 0, 0, w, S_MEM, 2'd1, w, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not reach the end, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc(0, 0, 0, 0, 0, W_NOP, S_FET, 2'd0, W_FETCH, 0);
        cyc(0, 1, 0, 1, 1, W_LD,  S_FET, 2'd0, W_FETCH, 0);

        // ALU instruction, then run ignored in FETCH
        aluInstr(W_ALU);
        cyc(1, 0, 0, 0, 1, W_NOP, S_FET, 2'd0, W_FETCH, 0);

        // Load: three MEM_WAIT cycles, instr_valid ignored, mem_ready wins
        loadStart(W_LD);
        cyc(1, 1, 0, 0, 0, W_LD, S_MEM, 2'd1, W_LD, 0);
        cyc(1, 0, 0, 0, 0, W_LD, S_MEM, 2'd1, W_LD, 0);
        expRet = expRet + 16'd1;
        cyc(1, 1, 0, 1, 0, W_LD, S_FET, 2'd0, W_FETCH, 0);
        cyc(1, 0, 0, 0, 0, W_LD, S_FET, 2'd0, W_FETCH, 0);

        // HALT retires on entry, run 10 cycles later restarts
        cyc(1, 1, 0, 0, 0, W_NOP, S_DEC, 2'd2, W_NOP, 0);
        expRet = expRet + 16'd1;
        cyc(1, 0, 1, 0, 0, W_NOP, S_HLT, 2'd3, W_HALT, 0);
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 0, W_NOP, S_HLT, 2'd3, W_HALT, 0);
        cyc(1, 0, 0, 0, 1, W_NOP, S_FET, 2'd0, W_FETCH, 0);

`ifdef MEM_TIMEOUT_EN
        // 15 MEM_WAIT cycles then FAULT; run clears it
        loadStart(W_LD);
        for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0, W_LD, S_MEM, 2'd1, W_LD, 0);
        cyc(1, 0, 0, 0, 0, W_LD, S_FLT, 2'd3, W_HALT, 1);
        cyc(1, 0, 0, 0, 0, W_LD, S_FLT, 2'd3, W_HALT, 1);
        cyc(1, 0, 0, 0, 1, W_LD, S_FET, 2'd0, W_FETCH, 0);
        // mem_ready on the limit cycle beats the timeout
        loadStart(W_LD);
        for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0, W_LD, S_MEM, 2'd1, W_LD, 0);
        expRet = expRet + 16'd1;
        cyc(1, 0, 0, 1, 0, W_LD, S_FET, 2'd0, W_FETCH, 0);
`else
        // Without the timeout MEM_WAIT holds indefinitely and fault stays low
        loadStart(W_LD);
        for (int i = 0; i < 24; i++) cyc(1, 0, 0, 0, 0, W_LD, S_MEM, 2'd1, W_LD, 0);
        expRet = expRet + 16'd1;
        cyc(1, 0, 0, 1, 0, W_LD, S_FET, 2'd0, W_FETCH, 0);
`endif

        // Reset during MEM_WAIT abandons the load
        loadStart(W_LD);
        cyc(1, 0, 0, 0, 0, W_LD, S_MEM, 2'd1, W_LD, 0);
        expRet = '0;
        cyc(0, 0, 0, 0, 0, W_LD, S_FET, 2'd0, W_FETCH, 0);
        cyc(1, 0, 0, 1, 0, W_LD, S_FET, 2'd0, W_FETCH, 0);

        // Counter wrap: preload near the top, then retire two instructions
        @(negedge clock);
        force dut.retiredQ = 16'hFFFE;
        #1;
        release dut.retiredQ;
        expRet = 16'hFFFE;
        aluInstr(W_ALU);
        aluInstr(W_ALU);
        cyc(1, 0, 0, 0, 0, W_NOP, S_FET, 2'd0, W_FETCH, 0);

        @(negedge clock);
        @(posedge clock);
        #2;
        chk("queue_drained", tagN, 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The module SHALL have parameter CW_W, default 47, meaning the control-word width.
REQ-002 The module SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum memory wait cycles before a fault.
REQ-003 The clock and reset SHALL be: clock (input, 1 bit), the single clock, and reset (input, 1 bit), synchronous, active-low.
REQ-004 Port instr_valid SHALL be an input, 1 bit: fetched instruction present on the decoder this cycle.
REQ-005 Port decoded_cw SHALL be an input, CW_W bits: the control word from the combinational decoder for the current instruction.
REQ-006 Port is_halt SHALL be an input, 1 bit: the decoded instruction is HALT.
REQ-007 Port mem_ready SHALL be an input, 1 bit: the data memory has completed the access.
REQ-008 Port run SHALL be an input, 1 bit: a one-cycle pulse that restarts the machine from HALT or FAULT.
REQ-009 Port control_word SHALL be an output, CW_W bits: the word driving the datapath.
REQ-010 Port cw_sel SHALL be an output, 2 bits: the select for the 4:1 control-word mux, with 0=IF, 1=EXEC, 2=NOP, 3=HALT.
REQ-011 Port state SHALL be an output, 3 bits: the current FSM state encoding.
REQ-012 Port retired SHALL be an output, 16 bits: the count of instructions completed.
REQ-013 Port fault SHALL be an output, 1 bit: high while in FAULT.

Function
REQ-014 The FSM states SHALL be FETCH, DECODE, EXECUTE, MEM_WAIT, HALTED and FAULT.
REQ-015 In FETCH, the block SHALL drive cw_sel=0 and control_word=CW_FETCH; it SHALL go to DECODE when instr_valid=1 and otherwise stay in FETCH.
REQ-016 In DECODE, the block SHALL register decoded_cw into cw_hold and drive cw_sel=2 with CW_NOP; it SHALL go to HALTED if is_halt=1, else to EXECUTE.
REQ-017 In EXECUTE, the block SHALL drive cw_sel=1 and control_word=cw_hold; if cw_hold[CW_MEM_BIT]=1 it SHALL go to MEM_WAIT, else to FETCH.
REQ-018 In MEM_WAIT, the block SHALL hold control_word=cw_hold with cw_sel=1; it SHALL go to FETCH on mem_ready=1.
REQ-019 In HALTED, the block SHALL drive cw_sel=3 and CW_HALT; a run pulse SHALL go to FETCH, and run in any other state SHALL be ignored.
REQ-020 In FAULT, the block SHALL drive cw_sel=3, CW_HALT and fault=1; a run pulse SHALL clear the fault and go to FETCH.
REQ-021 retired SHALL increment by 1 on each transition EXECUTE->FETCH or MEM_WAIT->FETCH, and SHALL wrap from 0xFFFF to 0x0000.
REQ-022 A HALT instruction SHALL increment retired on entering HALTED.
REQ-023 control_word and cw_sel SHALL be registered, valid in the cycle the state is entered (one cycle after the transition decision).
REQ-024 If instr_valid and mem_ready are high together in MEM_WAIT, mem_ready SHALL take priority; instr_valid SHALL be sampled only in FETCH.

Reset
REQ-025 While reset=0 at a clock edge, the block SHALL enter FETCH with control_word=CW_FETCH, cw_sel=0, retired=0, cw_hold=CW_NOP, fault=0 and the wait counter at 0.
REQ-026 Reset asserted mid-operation, including during MEM_WAIT, SHALL abandon the instruction without incrementing retired.

Configuration
REQ-027 With MEM_TIMEOUT_EN defined, a 4-bit wait counter SHALL count cycles in MEM_WAIT; reaching MEM_TIMEOUT without mem_ready SHALL enter FAULT, and mem_ready on the same cycle SHALL win.
REQ-028 Without MEM_TIMEOUT_EN, MEM_WAIT SHALL wait indefinitely, fault SHALL be tied to 0, and FAULT SHALL be unreachable.

Structure
REQ-029 The shared package SHALL hold the state encoding, the cw_sel codes, CW_FETCH, CW_NOP, CW_HALT, CW_MEM_BIT and CW_W.
REQ-030 CW_FETCH SHALL be the existing instruction-fetch control word, with PC-select field 01, PC load and instruction load set.
REQ-031 The output select SHALL reuse the existing 4:1 control-word mux as its only sub-module, driven from the registered cw_sel; no other sub-module is required.

Verification
REQ-032 ALU instruction: reset, then instr_valid=1 with cw_hold[CW_MEM_BIT]=0 -> state sequence FETCH, DECODE, EXECUTE, FETCH in 4 cycles, retired=1.
REQ-033 Load instruction: mem bit set, mem_ready after 3 cycles -> 3 MEM_WAIT cycles with control_word held, then FETCH and retired=1.
REQ-034 HALT: is_halt=1 -> HALTED with cw_sel=3 and retired incremented; a run pulse 10 cycles later -> FETCH next cycle.
REQ-035 Timeout: with MEM_TIMEOUT_EN defined, mem_ready held low -> FAULT after 15 MEM_WAIT cycles with fault=1; run -> FETCH with fault=0.
REQ-036 Wrap: preload via 65535 retired instructions, then one more -> retired=0x0000.
REQ-037 Reset in MEM_WAIT: reset=0 for 1 cycle -> FETCH, retired=0, control_word=CW_FETCH.
